fill_valve_arbiter: RTL and testbench

Shares one building water main among `N_MACHINES` washing-machine controllers. Each controller's fill-valve request (its `fill_value_on` output) arrives here; the arbiter grants the main to one machine at a time in round-robin order. It enforces a maximum fill slot per grant and a pressure-recovery gap between grants. It sits between the per-machine FSMs and the physical inlet valves.

---
 rtl/washer_pkg.sv | 15 +
 rtl/rr_picker.sv | 24 ++
 rtl/fill_valve_arbiter.sv | 124 ++++++++++++
 tb/tb_fill_valve_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared types and default constants for the laundry-room controllers.
package washer_pkg;

    // Arbiter sequencing: wait for a request, hold the main, let pressure recover.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Defaults sized for the building main: ~1k cycle fill slot, short recovery.
    localparam int MAX_FILL_CYCLES_DEF = 1024;
    localparam int GAP_CYCLES_DEF      = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int N_MACHINES = 4,
    parameter int IDW        = $clog2(N_MACHINES)
) (
    input  logic [N_MACHINES-1:0] req,
    input  logic [IDW-1:0]        ptr,
    output logic                  found,
    output logic [IDW-1:0]        index
);

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N_MACHINES - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_MACHINES]) begin
                found = 1'b1;
                index = IDW'((int'(ptr) + i) % N_MACHINES);
            end
        end
    end

endmodule

// File: rtl/fill_valve_arbiter.sv
// Grants the shared water main to one washer at a time, round-robin, with a
// bounded fill slot and a pressure-recovery gap between grants.
//
// Request/grant semantics: fill_req[i] is a level held by machine i for as long
// as it wants water; grant[i] is the acknowledgement and stays high until the
// machine reports filled[i], drops fill_req[i], or its slot runs out. A request
// is only sampled by arbitration in IDLE; nothing preempts an active grant.
module fill_valve_arbiter
    import washer_pkg::*;
#(
    parameter int N_MACHINES      = 4,
    parameter int MAX_FILL_CYCLES = MAX_FILL_CYCLES_DEF,
    parameter int GAP_CYCLES      = GAP_CYCLES_DEF,
    parameter int IDW             = $clog2(N_MACHINES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_MACHINES-1:0] fill_req,
    input  logic [N_MACHINES-1:0] filled,
    output logic [N_MACHINES-1:0] grant,
    output logic                  valve_open,
    output logic [IDW-1:0]        active_id,
    output logic [N_MACHINES-1:0] slot_expired,
    output logic [1:0]            state_dbg
);

    localparam int CW       = $clog2(MAX_FILL_CYCLES);
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] FILL_LAST = CW'(MAX_FILL_CYCLES - 1);
    localparam logic [CW-1:0] FILL_SAT  = '1;
    localparam logic [GW-1:0] GAP_END   = GW'(GAP_LAST);

    arb_state_t            state, state_n;
    logic [CW-1:0]         fill_cnt, fill_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic [IDW-1:0]        ptr, ptr_n;
    logic [IDW-1:0]        id_n;
    logic [N_MACHINES-1:0] grant_n, expired_n;
    logic                  pick_found;
    logic [IDW-1:0]        pick_idx;
    logic                  normal_rel, forced_rel;

    rr_picker #(
        .N_MACHINES (N_MACHINES),
        .IDW        (IDW)
    ) u_picker (
        .req   (fill_req),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign normal_rel = filled[active_id] | ~fill_req[active_id];
    assign forced_rel = (fill_cnt == FILL_LAST);
    assign valve_open = |grant;
    assign state_dbg  = state;

    // State, counters, pointer and all outputs are registered; reset drops the valve at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            gap_cnt      <= '0;
            ptr          <= '0;
            grant        <= '0;
            active_id    <= '0;
            slot_expired <= '0;
        end else begin
            state        <= state_n;
            fill_cnt     <= fill_n;
            gap_cnt      <= gap_n;
            ptr          <= ptr_n;
            grant        <= grant_n;
            active_id    <= id_n;
            slot_expired <= expired_n;
        end
    end

    // Arbitrate in IDLE, supervise the slot in FILL, hold the main closed in GAP.
    always_comb begin
        state_n   = state;
        fill_n    = fill_cnt;
        gap_n     = gap_cnt;
        ptr_n     = ptr;
        grant_n   = grant;
        id_n      = active_id;
        expired_n = '0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (pick_found) begin
                    grant_n = N_MACHINES'(1) << pick_idx;
                    id_n    = pick_idx;
                    fill_n  = '0;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (normal_rel || forced_rel) begin
                    grant_n = '0;
                    // A normal release in the same cycle as the timeout is not an expiry.
                    if (!normal_rel) expired_n = grant;
                    ptr_n   = (active_id == IDW'(N_MACHINES - 1)) ? '0 : active_id + IDW'(1);
                    gap_n   = '0;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (fill_cnt != FILL_SAT) begin
                    fill_n = fill_cnt + CW'(1);
                end
            end
            GAP: begin
                grant_n = '0;
                if (gap_cnt == GAP_END) state_n = IDLE;
                else                    gap_n   = gap_cnt + GW'(1);
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Bench for fill_valve_arbiter: directed scenarios plus randomized traffic
// checked against an event-level model of the arbitration rules.
module tb_fill_valve_arbiter;
    import washer_pkg::*;

    localparam int N    = 4;
    localparam int MAXF = 16;
    localparam int GAPC = 4;
    localparam int IDW  = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   fill_req = '0;
    logic [N-1:0]   filled = '0;
    logic [N-1:0]   grant;
    logic           valve_open;
    logic [IDW-1:0] active_id;
    logic [N-1:0]   slot_expired;
    logic [1:0]     state_dbg;

    int checks = 0;
    int errors = 0;

    // Model: who owns the main, how long, zero-cycles since release, next priority.
    int           m_owner;
    int           m_len;
    int           m_zero;
    int           m_ptr;
    int           m_id;
    logic [N-1:0] m_pulse;

    fill_valve_arbiter #(
        .N_MACHINES      (N),
        .MAX_FILL_CYCLES (MAXF),
        .GAP_CYCLES      (GAPC),
        .IDW             (IDW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fill_req     (fill_req),
        .filled       (filled),
        .grant        (grant),
        .valve_open   (valve_open),
        .active_id    (active_id),
        .slot_expired (slot_expired),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_len   = 0;
        m_zero  = GAPC + 1;
        m_ptr   = 0;
        m_id    = 0;
        m_pulse = '0;
    endtask

    // Apply one clock edge's worth of the rules to the model.
    task automatic model_edge();
        m_pulse = '0;
        if (m_owner >= 0) begin
            if (filled[m_owner] || !fill_req[m_owner] || m_len == MAXF) begin
                if (!(filled[m_owner] || !fill_req[m_owner])) m_pulse = N'(1) << m_owner;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_zero  = 0;
            end else begin
                m_len++;
            end
        end else begin
            m_zero++;
            if (m_zero >= GAPC + 1 && fill_req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (fill_req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_id  = m_owner;
                m_len = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b0;
        fill_req = '0;
        filled   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (!valve_open && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (valve_open !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_grant valve_open=%0b required=1 within 20 cycles", tag, valve_open);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        fill_req = '1;
        filled = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b required 0000", grant); end
        checks++;
        if (valve_open !== 1'b0) begin errors++; $display("FAIL reset_valve got %b required 0", valve_open); end
        checks++;
        if (active_id !== '0) begin errors++; $display("FAIL reset_id got %0d required 0", active_id); end
        checks++;
        if (slot_expired !== '0) begin errors++; $display("FAIL reset_expired got %b required 0000", slot_expired); end
        reset = 1'b1;
        fill_req = '0;
        model_reset();
    endtask

    task automatic test_single();
        int zeros;
        apply_reset();
        fill_req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b required 0100", grant); end
        checks++;
        if (active_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d required 2", active_id); end
        filled = 4'b0100;
        step();
        filled = '0;
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL single_release got %b required 0000", grant); end
        zeros = 1;
        while (!valve_open && zeros < 20) begin
            step();
            if (!valve_open) zeros++;
        end
        checks++;
        if (zeros != GAPC + 1) begin errors++; $display("FAIL single_gap got %0d zero cycles required %0d", zeros, GAPC + 1); end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        fill_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr");
            checks++;
            if (active_id !== IDW'(exp_order[k])) begin
                errors++;
                $display("FAIL rr_order[%0d] got %0d required %0d", k, active_id, exp_order[k]);
            end
            filled = N'(1) << active_id;
            step();
            filled = '0;
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        apply_reset();
        fill_req = 4'b0010;
        wait_grant("timeout");
        while (valve_open && hi < 40) begin
            hi++;
            step();
        end
        checks++;
        if (hi != MAXF) begin errors++; $display("FAIL timeout_len got %0d required %0d", hi, MAXF); end
        checks++;
        if (slot_expired !== 4'b0010) begin errors++; $display("FAIL timeout_pulse got %b required 0010", slot_expired); end
        fill_req = 4'b1110;
        step();
        checks++;
        if (slot_expired !== '0) begin errors++; $display("FAIL timeout_pulse_width got %b required 0000", slot_expired); end
        wait_grant("timeout_next");
        checks++;
        if (active_id !== 2'd2) begin errors++; $display("FAIL timeout_next_id got %0d required 2", active_id); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        fill_req = 4'b0001;
        wait_grant("simul");
        repeat (MAXF - 1) step();
        checks++;
        if (valve_open !== 1'b1) begin errors++; $display("FAIL simul_still_open got %b required 1", valve_open); end
        filled = 4'b0001;
        step();
        filled = '0;
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL simul_release got %b required 0000", grant); end
        checks++;
        if (slot_expired !== '0) begin errors++; $display("FAIL simul_no_pulse got %b required 0000", slot_expired); end
    endtask

    task automatic test_withdraw();
        apply_reset();
        fill_req = 4'b1000;
        wait_grant("withdraw");
        repeat (3) step();
        fill_req = '0;
        step();
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL withdraw_release got %b required 0000", grant); end
        checks++;
        if (state_dbg !== GAP) begin errors++; $display("FAIL withdraw_state got %0d required %0d", state_dbg, GAP); end
        fill_req = 4'b1000;
        repeat (GAPC) step();
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL withdraw_gap got %b required 0000", grant); end
        step();
        checks++;
        if (grant !== 4'b1000) begin errors++; $display("FAIL withdraw_regrant got %b required 1000", grant); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        fill_req = 4'b0100;
        wait_grant("async");
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL async_grant got %b required 0000", grant); end
        checks++;
        if (valve_open !== 1'b0) begin errors++; $display("FAIL async_valve got %b required 0", valve_open); end
        checks++;
        if (slot_expired !== '0) begin errors++; $display("FAIL async_expired got %b required 0000", slot_expired); end
        fill_req = 4'b1010;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL async_first_grant got %b required 0010", grant); end
        checks++;
        if (active_id !== 2'd1) begin errors++; $display("FAIL async_first_id got %0d required 1", active_id); end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) fill_req[i] = ~fill_req[i];
                filled[i] = ($urandom_range(0, 24) == 0);
            end
            step();
            exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            checks++;
            if (grant !== exp_g) begin errors++; $display("FAIL rand_grant cycle %0d got %b required %b", c, grant, exp_g); end
            checks++;
            if (valve_open !== (m_owner >= 0)) begin errors++; $display("FAIL rand_valve cycle %0d got %b required %b", c, valve_open, m_owner >= 0); end
            checks++;
            if (active_id !== IDW'(m_id)) begin errors++; $display("FAIL rand_id cycle %0d got %0d required %0d", c, active_id, m_id); end
            checks++;
            if (slot_expired !== m_pulse) begin errors++; $display("FAIL rand_expired cycle %0d got %b required %b", c, slot_expired, m_pulse); end
        end
        fill_req = '0;
        filled   = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
